// File: rtl/irq_collect_pkg.sv
// irq_collect_pkg: shared types, defaults and width helper for the request collector
package irq_collect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int N_DEFAULT = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder with any-valid flag
module irq_prio_enc import irq_collect_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]         vec,
    output logic [id_w(N)-1:0]   idx,
    output logic                 any
);

    localparam int IDW = id_w(N);

    // scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = IDW'(i);
    end

endmodule

// File: rtl/irq_collect.sv
// irq_collect: sticky edge-triggered pending bits arbitrated into one registered IRQ with ack handshake
module irq_collect import irq_collect_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         MASK,
    output logic                 IRQ,
    output logic [id_w(N)-1:0]   IRQ_ID,
    input  logic                 ACK,
    output logic [N-1:0]         PEND,
    output logic                 OVF,
    input  logic                 OVF_CLR
);

    localparam int IDW = id_w(N);

    logic [N-1:0]   req_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   cand;
    logic [IDW-1:0] enc_id;
    logic           any;
    logic           accept;
    logic           ovf_set;
    state_t         state, state_nxt;

    assign rise    = REQ & ~req_q;
    assign accept  = (state == BUSY) & ACK;
    assign clr     = accept ? ({{(N-1){1'b0}}, 1'b1} << IRQ_ID) : '0;
    assign cand    = PEND & MASK;
    assign ovf_set = |(rise & PEND & ~clr);

    irq_prio_enc #(.N(N)) u_enc (
        .vec (cand),
        .idx (enc_id),
        .any (any)
    );

    // previous REQ sample; loads through reset so a line held high gives no edge
    always_ff @(posedge CLK)
        req_q <= REQ;

    // sticky pending bits and overflow flag; a new event beats a same-cycle clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            PEND <= '0;
            OVF  <= 1'b0;
        end else begin
            PEND <= rise | (PEND & ~clr);
            OVF  <= ovf_set | (OVF & ~OVF_CLR);
        end
    end

    // handshake next-state: arbitrate in IDLE, hold in BUSY until ack, one gap cycle
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (any ? BUSY : IDLE)
                  : (state == BUSY) ? (ACK ? GAP : BUSY)
                  : IDLE;
    end

    // state register with registered IRQ and ID latched only on a new grant
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            IRQ    <= 1'b0;
            IRQ_ID <= '0;
        end else begin
            state  <= state_nxt;
            IRQ    <= (state_nxt == BUSY);
            IRQ_ID <= (state == IDLE && any) ? enc_id : IRQ_ID;
        end
    end

endmodule

// File: tb/tb_irq_collect.sv
// tb_irq_collect: scoreboard bench with a cycle-level reference model of the collector
module tb_irq_collect;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] pend;
        logic         irq;
        logic [2:0]   id;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] mask = '0;
    logic         ack = 1'b0;
    logic         ovf_clr = 1'b0;
    logic         irq;
    logic [2:0]   irq_id;
    logic [N-1:0] pend;
    logic         ovf;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    exp_t q[$];

    logic [N-1:0] m_req_q = '0;
    logic [N-1:0] m_pend = '0;
    logic         m_irq = 1'b0;
    logic [2:0]   m_id = '0;
    logic         m_ovf = 1'b0;
    logic         m_gap = 1'b0;

    irq_collect #(.N(N)) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .MASK    (mask),
        .IRQ     (irq),
        .IRQ_ID  (irq_id),
        .ACK     (ack),
        .PEND    (pend),
        .OVF     (ovf),
        .OVF_CLR (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passed++;
        else begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // model of the collector after one clock edge, from the behavioural rules
    task automatic model_step();
        logic [N-1:0] rise, clr, cand;
        logic         hit;
        if (rst) begin
            m_pend = '0; m_irq = 1'b0; m_id = '0; m_ovf = 1'b0; m_gap = 1'b0;
        end else begin
            rise = req & ~m_req_q;
            clr  = (m_irq && ack) ? (N'(1) << m_id) : '0;
            cand = m_pend & mask;
            m_ovf = ((rise & m_pend & ~clr) != 0) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            if (m_irq) begin
                if (ack) begin m_irq = 1'b0; m_gap = 1'b1; end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (cand != 0) begin
                hit = 1'b0;
                for (int i = 0; i < N; i++)
                    if (cand[i] && !hit) begin m_id = 3'(i); hit = 1'b1; end
                m_irq = 1'b1;
            end
            m_pend = rise | (m_pend & ~clr);
        end
        m_req_q = req;
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] mk,
                       input logic a, input logic oc);
        @(negedge clk);
        #1;
        rst = r; req = rq; mask = mk; ack = a; ovf_clr = oc;
        model_step();
        q.push_back('{pend: m_pend, irq: m_irq, id: m_id, ovf: m_ovf});
    endtask

    // monitor: one expected record per clock edge, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pend",   int'(pend),   int'(e.pend));
            check("irq",    int'(irq),    int'(e.irq));
            check("irq_id", int'(irq_id), int'(e.id));
            check("ovf",    int'(ovf),    int'(e.ovf));
        end
    end

    initial begin
        // 1: reset with all lines held high, no edges afterwards
        cyc(1, 8'hFF, 8'hFF, 0, 0);
        cyc(1, 8'hFF, 8'hFF, 0, 0);
        repeat (4) cyc(0, 8'hFF, 8'hFF, 0, 0);
        // 2: single line 5 rise, grant, ack
        cyc(0, 8'h00, 8'hFF, 0, 0);
        cyc(0, 8'h20, 8'hFF, 0, 0);
        cyc(0, 8'h20, 8'hFF, 0, 0);
        cyc(0, 8'h20, 8'hFF, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0);
        // 3: lines 2 and 6 together, lowest first then 6 after the gap
        cyc(0, 8'h44, 8'hFF, 0, 0);
        cyc(0, 8'h44, 8'hFF, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0);
        repeat (3) cyc(0, 8'h00, 8'hFF, 0, 0);
        cyc(0, 8'h00, 8'hFF, 1, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0);
        // 4: masked line 3 pends silently until unmasked
        cyc(0, 8'h08, 8'h00, 0, 0);
        repeat (3) cyc(0, 8'h08, 8'h00, 0, 0);
        cyc(0, 8'h08, 8'h08, 0, 0);
        cyc(0, 8'h08, 8'h08, 0, 0);
        cyc(0, 8'h00, 8'h00, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 0);
        repeat (2) cyc(0, 8'h00, 8'hFF, 0, 0);
        // 5: re-rise in ack cycle, overflow, clear racing a new overflow
        cyc(0, 8'h10, 8'hFF, 0, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0);
        cyc(0, 8'h10, 8'hFF, 1, 0);
        repeat (3) cyc(0, 8'h00, 8'hFF, 0, 0);
        cyc(0, 8'h10, 8'hFF, 0, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0);
        cyc(0, 8'h10, 8'hFF, 0, 1);
        cyc(0, 8'h10, 8'hFF, 0, 1);
        cyc(0, 8'h00, 8'hFF, 1, 0);
        repeat (2) cyc(0, 8'h00, 8'hFF, 0, 0);
        // 6: reset in the middle of a handshake, late ack ignored
        cyc(0, 8'h01, 8'hFF, 0, 0);
        repeat (2) cyc(0, 8'h01, 8'hFF, 0, 0);
        cyc(1, 8'h01, 8'hFF, 0, 0);
        cyc(0, 8'h01, 8'hFF, 1, 0);
        repeat (2) cyc(0, 8'h01, 8'hFF, 0, 0);
        // randomized traffic
        for (int k = 0; k < 3000; k++)
            cyc(($urandom_range(0, 99) == 0), req ^ 8'($urandom & $urandom),
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
